// File: rtl/conv2d_compute_strided.sv
// Single-MAC 2D convolution engine: loads a WT_DIM x WT_DIM kernel once, then
// walks the whole output map with a runtime stride, zero-padding the borders.
module conv2d_compute_strided #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int WT_DIM = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     idle,
  input  logic [31:0]              fm_dim,
  input  logic [1:0]               stride,
  input  logic                     relu_en,
  output logic [31:0]              cur_x,
  output logic [31:0]              cur_y,
  output logic [31:0]              win_m,
  output logic [31:0]              win_n,
  input  logic signed [DWIDTH-1:0] rdata,
  input  logic                     rdata_valid,
  output logic                     rdata_ready,
  output logic signed [DWIDTH-1:0] wdata,
  output logic                     wdata_valid,
  input  logic                     wdata_ready
);

  localparam int WT_SIZE = WT_DIM * WT_DIM;
  localparam logic [2:0] LAST = 3'(WT_DIM - 1);
  localparam logic signed [31:0] HALF = 32'(WT_DIM / 2);

  if (WT_DIM < 1 || WT_DIM > 7 || (WT_DIM % 2) == 0 || AWIDTH < 1) begin : g_bad_param
    $error("conv2d_compute_strided: WT_DIM must be odd in 1..7 and AWIDTH >= 1");
  end

  typedef enum logic [1:0] {IDLE, READ_WT, COMPUTE, DONE} state_t;

  state_t                   state, state_nx;
  logic [31:0]              fm_dim_r;
  logic [1:0]               stride_r;
  logic                     relu_r;
  logic [2:0]               m_cnt, n_cnt, m_nx, n_nx;
  logic signed [DWIDTH-1:0] acc;
  logic signed [DWIDTH-1:0] wt [WT_SIZE];
  logic signed [31:0]       idx, idy;
  logic                     halo, kern_last, step_done, rd_fire;
  logic [32:0]              x_adv, y_adv, fm_max;
  logic                     x_fits, map_done;

  // Signed DWIDTH x DWIDTH product truncated back to DWIDTH (wraps).
  function automatic logic signed [DWIDTH-1:0] mul_trunc(
    input logic signed [DWIDTH-1:0] a,
    input logic signed [DWIDTH-1:0] b
  );
    logic signed [2*DWIDTH-1:0] p;
    p = a * b;
    return p[DWIDTH-1:0];
  endfunction

  // Optional ReLU clamp of the finished accumulator.
  function automatic logic signed [DWIDTH-1:0] relu_clamp(
    input logic signed [DWIDTH-1:0] a,
    input logic                     en
  );
    return (en && a[DWIDTH-1]) ? '0 : a;
  endfunction

  assign win_m   = {29'd0, m_cnt};
  assign win_n   = {29'd0, n_cnt};
  assign rd_fire = rdata_valid & rdata_ready;
  assign wdata   = (state == DONE) ? relu_clamp(acc, relu_r) : '0;

  // Window geometry: halo detection, kernel counter stepping, window advance.
  always_comb begin
    idx       = $signed(cur_x) - HALF + $signed({29'd0, n_cnt});
    idy       = $signed(cur_y) - HALF + $signed({29'd0, m_cnt});
    halo      = idx[31] | idy[31] | ($unsigned(idx) >= fm_dim_r) | ($unsigned(idy) >= fm_dim_r);
    kern_last = (m_cnt == LAST) && (n_cnt == LAST);
    n_nx      = n_cnt + 3'd1;
    m_nx      = m_cnt;
    if (n_cnt == LAST) begin
      n_nx = 3'd0;
      m_nx = (m_cnt == LAST) ? 3'd0 : m_cnt + 3'd1;
    end
    x_adv    = {1'b0, cur_x} + {31'd0, stride_r};
    y_adv    = {1'b0, cur_y} + {31'd0, stride_r};
    fm_max   = {1'b0, fm_dim_r} - 33'd1;
    x_fits   = (x_adv <= fm_max);
    map_done = (y_adv > fm_max);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx    = state;
    idle        = 1'b0;
    rdata_ready = 1'b0;
    wdata_valid = 1'b0;
    step_done   = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (start) state_nx = READ_WT;
      end
      READ_WT: begin
        rdata_ready = 1'b1;
        if (rdata_valid && kern_last) state_nx = COMPUTE;
      end
      COMPUTE: begin
        rdata_ready = ~halo;
        step_done   = halo | rdata_valid;
        if (step_done && kern_last) state_nx = DONE;
      end
      DONE: begin
        wdata_valid = 1'b1;
        if (wdata_ready) state_nx = (!x_fits && map_done) ? IDLE : COMPUTE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Configuration latch, weight shift/rotate, accumulator and coordinate counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fm_dim_r <= 32'd1;
      stride_r <= 2'd1;
      relu_r   <= 1'b0;
      m_cnt    <= 3'd0;
      n_cnt    <= 3'd0;
      cur_x    <= 32'd0;
      cur_y    <= 32'd0;
      acc      <= '0;
      for (int i = 0; i < WT_SIZE; i++) wt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            fm_dim_r <= fm_dim;
            stride_r <= (stride == 2'd2) ? 2'd2 : 2'd1;
            relu_r   <= relu_en;
            m_cnt    <= 3'd0;
            n_cnt    <= 3'd0;
            cur_x    <= 32'd0;
            cur_y    <= 32'd0;
          end
        end
        READ_WT: begin
          if (rd_fire) begin
            for (int i = 0; i < WT_SIZE - 1; i++) wt[i] <= wt[i+1];
            wt[WT_SIZE-1] <= rdata;
            m_cnt <= m_nx;
            n_cnt <= n_nx;
            if (kern_last) acc <= '0;
          end
        end
        COMPUTE: begin
          if (step_done) begin
            acc <= acc + (halo ? '0 : mul_trunc(wt[0], rdata));
            for (int i = 0; i < WT_SIZE - 1; i++) wt[i] <= wt[i+1];
            wt[WT_SIZE-1] <= wt[0];
            m_cnt <= m_nx;
            n_cnt <= n_nx;
          end
        end
        DONE: begin
          if (wdata_ready) begin
            acc <= '0;
            if (x_fits) begin
              cur_x <= x_adv[31:0];
            end else begin
              cur_x <= 32'd0;
              cur_y <= y_adv[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_compute_strided.sv
// Randomized bench for conv2d_compute_strided against a direct convolution model.
module tb_conv2d_compute_strided;
  localparam int WD = 3;
  localparam int WS = WD * WD;

  logic               clk = 1'b0;
  logic               rst, start, idle, relu_en;
  logic [31:0]        fm_dim, cur_x, cur_y, win_m, win_n;
  logic [1:0]         stride;
  logic signed [31:0] rdata, wdata;
  logic               rdata_valid, rdata_ready, wdata_valid, wdata_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int img [8][8];
  int wts [WS];
  int expq [$];
  logic [31:0] gotq [$];

  conv2d_compute_strided #(.AWIDTH(32), .DWIDTH(32), .WT_DIM(WD)) dut (
    .clk(clk), .rst(rst), .start(start), .idle(idle), .fm_dim(fm_dim),
    .stride(stride), .relu_en(relu_en), .cur_x(cur_x), .cur_y(cur_y),
    .win_m(win_m), .win_n(win_n), .rdata(rdata), .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready), .wdata(wdata), .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Direct convolution over the strided output grid with zero padding.
  function automatic void model(input int fm, input int st, input bit relu);
    int s, acc, iy, ix;
    s = (st == 2) ? 2 : 1;
    expq.delete();
    for (int y = 0; y < fm; y += s)
      for (int x = 0; x < fm; x += s) begin
        acc = 0;
        for (int m = 0; m < WD; m++)
          for (int n = 0; n < WD; n++) begin
            iy = y - WD / 2 + m;
            ix = x - WD / 2 + n;
            if (iy >= 0 && iy < fm && ix >= 0 && ix < fm)
              acc += wts[m*WD+n] * img[iy][ix];
          end
        if (relu && acc < 0) acc = 0;
        expq.push_back(acc);
      end
  endfunction

  task automatic fill(input int wmode, input int imode);
    for (int i = 0; i < WS; i++)
      wts[i] = (wmode == 0) ? 1 : (wmode == 1) ? -1 : $signed($urandom_range(0, 2000)) - 1000;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        img[y][x] = (imode == 0) ? 1 : $signed($urandom);
  endtask

  // One full-map job; abort_after > 0 leaves the DUT mid-job after that many cycles.
  task automatic run_job(input int fm, input int st, input bit relu, input int vprob,
                         input int rprob, input int stall_n, input int abort_after);
    int wcnt, cyc, stalled, ix, iy;
    bit hl;
    logic [31:0] hold_w, hold_x, hold_y;
    model(fm, st, relu);
    gotq.delete();
    start = 1'b1; fm_dim = 32'(fm); stride = 2'(st); relu_en = relu;
    @(posedge clk); @(negedge clk);
    start = 1'b0; fm_dim = $urandom; stride = 2'($urandom); relu_en = ~relu;
    chk("busy", 32'(idle), 32'd0);
    wcnt = 0; cyc = 0; stalled = 0;
    hold_w = '0; hold_x = '0; hold_y = '0;
    while (cyc < 20000 && !idle && !(abort_after > 0 && cyc == abort_after)) begin
      rdata_valid = ($urandom_range(0, 99) < vprob);
      ix = int'(cur_x) - WD / 2 + int'(win_n);
      iy = int'(cur_y) - WD / 2 + int'(win_m);
      hl = (ix < 0 || ix >= fm || iy < 0 || iy >= fm);
      if (wcnt < WS) rdata = wts[wcnt];
      else           rdata = hl ? $signed($urandom) : img[iy][ix];
      wdata_ready = ($urandom_range(0, 99) < rprob);
      if (wdata_valid && gotq.size() == 0 && stalled < stall_n) begin
        wdata_ready = 1'b0;
        if (stalled == 0) begin
          hold_w = wdata; hold_x = cur_x; hold_y = cur_y;
        end else begin
          chk("stall_valid", 32'(wdata_valid), 32'd1);
          chk("stall_wdata", wdata, hold_w);
          chk("stall_x", cur_x, hold_x);
          chk("stall_y", cur_y, hold_y);
          chk("stall_m", win_m, 32'd0);
        end
        stalled++;
      end
      if (wcnt >= WS)
        chk("rdata_ready", 32'(rdata_ready), wdata_valid ? 32'd0 : 32'(!hl));
      if (rdata_valid && rdata_ready && wcnt < WS) wcnt++;
      if (wdata_valid && wdata_ready) gotq.push_back(wdata);
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    rdata_valid = 1'b0;
    wdata_ready = 1'b0;
    if (abort_after == 0) begin
      chk("job_done_idle", 32'(idle), 32'd1);
      chk("out_count", 32'(gotq.size()), 32'(expq.size()));
      for (int i = 0; i < gotq.size() && i < expq.size(); i++)
        chk($sformatf("ofm[%0d]", i), gotq[i], 32'(expq[i]));
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_rdy", 32'(rdata_ready), 32'd0);
    chk("rst_wvld", 32'(wdata_valid), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_x", cur_x, 32'd0);
    chk("rst_y", cur_y, 32'd0);
    chk("rst_m", win_m, 32'd0);
    chk("rst_n", win_n, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fm_dim = 32'd4; stride = 2'd1; relu_en = 1'b0;
    rdata = '0; rdata_valid = 1'b0; wdata_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();

    fill(0, 0); run_job(4, 1, 1'b0, 100, 100, 0, 0);
    fill(0, 0); run_job(5, 2, 1'b0, 100, 100, 0, 0);
    fill(1, 0); run_job(3, 1, 1'b0, 100, 100, 0, 0);
    fill(1, 0); run_job(3, 1, 1'b1, 100, 100, 0, 0);
    fill(0, 0); run_job(4, 1, 1'b0, 100, 100, 5, 0);
    fill(2, 1); run_job(1, 1, 1'b0, 70, 70, 0, 0);
    fill(2, 1); run_job(5, 3, 1'b0, 60, 60, 0, 0);
    for (int t = 0; t < 6; t++) begin
      fill(2, 1);
      run_job($urandom_range(1, 7), $urandom_range(1, 2), 1'($urandom), 50, 60,
              $urandom_range(0, 4), 0);
    end

    // Abort mid-COMPUTE, with a start coinciding with reset.
    fill(2, 1); run_job(5, 1, 1'b0, 100, 100, 0, WS + 4);
    chk("mid_busy", 32'(idle), 32'd0);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_reset_outputs();
    @(posedge clk); @(negedge clk);
    chk("start_with_rst_ignored", 32'(idle), 32'd1);
    fill(2, 1); run_job(4, 2, 1'b1, 50, 50, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
